sram_window_reader: RTL and testbench

Parametrised read-back engine for the SRAM frame buffer. On a start pulse it streams a rectangular window (origin, width, height) of a stored frame out over a valid/ready pixel interface with start-of-frame and end-of-line markers. Flow control is credit-based, so a stalling consumer never causes lost SRAM data. It sits between the SRAM arbiter (read port) and downstream image-processing or display stages, and generalises the fixed full-frame output reader.

---
 rtl/sram_window_reader_pkg.sv | 17 +
 rtl/sram_window_reader_if.sv | 34 +++
 rtl/sram_window_reader_sync_fifo.sv | 51 +++++
 rtl/sram_window_reader.sv | 175 +++++++++++++++++
 tb/tb_sram_window_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_window_reader_pkg.sv
// Shared types and default sizes for the SRAM window read-back engine.
package sram_rd_pkg;

  localparam int DEF_ADDR_W  = 19;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_IMG_W   = 640;
  localparam int DEF_COORD_W = 10;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic [DEF_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/sram_window_reader_if.sv
// SRAM read port plus outgoing pixel stream; master is the window reader.
interface sram_window_reader_if
  import sram_rd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              sram_sel;
  logic              sram_we;
  logic              sram_re;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    output sram_sel, sram_we, sram_re, sram_addr,
    input  sram_rdata,
    output pix_data, pix_valid, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  sram_sel, sram_we, sram_re, sram_addr,
    output sram_rdata,
    input  pix_data, pix_valid, pix_sof, pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/sram_window_reader_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head word is visible the cycle after push.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sram_window_reader.sv
// Streams a rectangular window of the SRAM frame buffer out as pixels, with
// credit-based flow control so a stalled consumer never loses returning data.
module sram_window_reader
  import sram_rd_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               wclk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] win_x,
  input  logic [COORD_W-1:0] win_y,
  input  logic [COORD_W-1:0] win_w,
  input  logic [COORD_W-1:0] win_h,
  output logic               busy,
  output logic               done,
  sram_window_reader_if.master bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = DATA_W + 2;

  state_t             state;
  state_t             next_state;
  logic [COORD_W-1:0] w_q;
  logic [COORD_W-1:0] h_q;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic [ADDR_W-1:0]  line_base;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  origin;
  logic [RD_LAT-1:0]  lat_valid;
  logic [RD_LAT-1:0]  lat_sof;
  logic [RD_LAT-1:0]  lat_eol;
  logic [CNT_W-1:0]   in_flight;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [BEAT_W-1:0]  fifo_head;
  logic               issue;
  logic               last_col;
  logic               last_read;
  logic               ret_valid;
  logic               pop;
  logic               drain_ok;

  assign origin    = ADDR_W'(win_y) * ADDR_W'(IMG_W) + ADDR_W'(win_x);
  assign last_col  = (col == w_q - COORD_W'(1));
  assign last_read = last_col && (row == h_q - COORD_W'(1));
  assign ret_valid = lat_valid[RD_LAT-1];
  assign pop       = ~fifo_empty & bus.pix_ready;

  // A slot is reserved for every read in flight, so the FIFO can always absorb returns.
  assign issue = (state == ISSUE) &&
                 (({1'b0, fifo_count} + {1'b0, in_flight}) < (CNT_W + 1)'(FIFO_DEPTH));

  // Finishing on the cycle of the final handshake keeps done one cycle after it.
  assign drain_ok = (in_flight == '0) &&
                    (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  always_ff @(posedge wclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = ((win_w == '0) || (win_h == '0)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue && last_read) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_ok) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.sram_sel  = issue | (in_flight != '0);
    bus.sram_we   = 1'b0;
    bus.sram_re   = issue;
    bus.sram_addr = addr;
    bus.pix_valid = ~fifo_empty;
    bus.pix_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    bus.pix_sof   = ~fifo_empty & fifo_head[DATA_W+1];
    bus.pix_eol   = ~fifo_empty & fifo_head[DATA_W];
    busy          = (state == ISSUE) || (state == DRAIN);
    done          = (state == DONE);
  end

  // addr tracks line_base + col as its own register so the SRAM address is a flop.
  always_ff @(posedge wclk) begin
    if (rst) begin
      w_q       <= '0;
      h_q       <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      addr      <= '0;
    end else if ((state == IDLE) && start) begin
      w_q       <= win_w;
      h_q       <= win_h;
      col       <= '0;
      row       <= '0;
      line_base <= origin;
      addr      <= origin;
    end else if (issue) begin
      if (last_col) begin
        col       <= '0;
        row       <= row + COORD_W'(1);
        line_base <= line_base + ADDR_W'(IMG_W);
        addr      <= line_base + ADDR_W'(IMG_W);
      end else begin
        col  <= col + COORD_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      lat_valid <= '0;
      lat_sof   <= '0;
      lat_eol   <= '0;
      in_flight <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        lat_valid[i] <= lat_valid[i-1];
        lat_sof[i]   <= lat_sof[i-1];
        lat_eol[i]   <= lat_eol[i-1];
      end
      lat_valid[0] <= issue;
      lat_sof[0]   <= (row == '0) && (col == '0);
      lat_eol[0]   <= last_col;
      in_flight    <= in_flight + CNT_W'(issue) - CNT_W'(ret_valid);
    end
  end

  sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wclk),
    .rst   (rst),
    .push  (ret_valid),
    .wdata ({lat_sof[RD_LAT-1], lat_eol[RD_LAT-1], bus.sram_rdata}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_window_reader.sv
// Scoreboard bench for sram_window_reader: SRAM model returns mem[a]=a, expected beats are queued per window.
module tb_sram_window_reader;
  import sram_rd_pkg::*;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 16;
  localparam int IMG_W      = 640;
  localparam int COORD_W    = 10;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic               wclk;
  logic               rst;
  logic               start;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;
  logic [COORD_W-1:0] win_w;
  logic [COORD_W-1:0] win_h;
  logic               busy;
  logic               done;

  sram_window_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_window_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .IMG_W      (IMG_W),
    .COORD_W    (COORD_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .wclk  (wclk),
    .rst   (rst),
    .start (start),
    .win_x (win_x),
    .win_y (win_y),
    .win_w (win_w),
    .win_h (win_h),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_re     = 0;
  int    n_hs     = 0;
  int    max_out  = 0;
  beat_t sb[$];

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // SRAM model: data is the low bits of the address, returned RD_LAT cycles later.
  logic [ADDR_W-1:0] addr_pipe [RD_LAT];
  always @(posedge wclk) begin
    addr_pipe[0] <= bus.sram_addr;
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign bus.sram_rdata = addr_pipe[RD_LAT-1][DATA_W-1:0];

  always @(negedge wclk) begin
    if (!rst) begin
      if (bus.sram_re) n_re++;
      if (bus.pix_valid && bus.pix_ready) begin
        beat_t got;
        beat_t exp;
        n_hs++;
        got.sof  = bus.pix_sof;
        got.eol  = bus.pix_eol;
        got.data = bus.pix_data;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL beat_unexpected: got %h, expected no beat", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL beat: got sof=%0b eol=%0b data=%0d, expected sof=%0b eol=%0b data=%0d",
                     got.sof, got.eol, got.data, exp.sof, exp.eol, exp.data);
          end
        end
      end
      if (n_re - n_hs > max_out) max_out = n_re - n_hs;
    end
  end

  task automatic push_window(input int x, input int y, input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        beat_t             b;
        logic [ADDR_W-1:0] a;
        a      = ADDR_W'((y + r) * IMG_W + x + c);
        b.sof  = (r == 0) && (c == 0);
        b.eol  = (c == w - 1);
        b.data = a[DATA_W-1:0];
        sb.push_back(b);
      end
    end
  endtask

  // Cycle 0 is the cycle start is high; k counts cycles after the accepting edge.
  task automatic run_window(input int x, input int y, input int w, input int h,
                            input int mode, input int restart_at,
                            output int done_cyc, output int first_re, output int first_valid,
                            output int re_at_20, output bit busy_c1, output bit busy_at_done);
    done_cyc = -1; first_re = -1; first_valid = -1; re_at_20 = -1;
    busy_c1 = 1'b0; busy_at_done = 1'b1;
    n_re = 0; n_hs = 0; max_out = 0;
    push_window(x, y, w, h);
    win_x = COORD_W'(x); win_y = COORD_W'(y); win_w = COORD_W'(w); win_h = COORD_W'(h);
    bus.pix_ready = (mode == 1) ? 1'b0 : 1'b1;
    start = 1'b1;
    @(posedge wclk); #1;
    for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
      case (mode)
        1:       bus.pix_ready = (k > 20);
        2:       bus.pix_ready = 1'($urandom_range(0, 1));
        default: bus.pix_ready = 1'b1;
      endcase
      if (k == restart_at) begin
        start = 1'b1;
        win_w = COORD_W'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge wclk); #1;
      if (bus.sram_re && first_re < 0) first_re = k;
      if (bus.pix_valid && first_valid < 0) first_valid = k;
      if (k == 1) busy_c1 = busy;
      if (k == 20) re_at_20 = n_re;
      if (done) begin
        done_cyc     = k;
        busy_at_done = busy;
      end
      @(posedge wclk); #1;
    end
    start = 1'b0;
    bus.pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.pix_ready = 1'b1;
    win_x = '0; win_y = '0; win_w = '0; win_h = '0;
    repeat (3) @(posedge wclk);
    #1;
    @(negedge wclk); #1;
    n_checks++;
    if ({bus.sram_sel, bus.sram_we, bus.sram_re} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_sram_ctrl: got %b, expected 000", {bus.sram_sel, bus.sram_we, bus.sram_re});
    end
    n_checks++;
    if (bus.sram_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_sram_addr: got %0d, expected 0", bus.sram_addr);
    end
    n_checks++;
    if ({bus.pix_valid, bus.pix_sof, bus.pix_eol} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_pix_ctrl: got %b, expected 000", {bus.pix_valid, bus.pix_sof, bus.pix_eol});
    end
    n_checks++;
    if (bus.pix_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_pix_data: got %0d, expected 0", bus.pix_data);
    end
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_busy_done: got %b, expected 00", {busy, done});
    end
    @(posedge wclk); #1;
    rst = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
  endtask

  task automatic test_full_throughput();
    int dc, fr, fv, r20;
    bit b1, bd;
    run_window(0, 0, 4, 2, 0, -1, dc, fr, fv, r20, b1, bd);
    n_checks++;
    if (dc !== 12) begin
      n_fail++;
      $display("[TB] FAIL full_done_cycle: got %0d, expected 12", dc);
    end
    n_checks++;
    if (fr !== 1) begin
      n_fail++;
      $display("[TB] FAIL full_first_re: got %0d, expected 1", fr);
    end
    n_checks++;
    if (fv !== 4) begin
      n_fail++;
      $display("[TB] FAIL full_first_valid: got %0d, expected 4", fv);
    end
    n_checks++;
    if ({b1, bd} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL full_busy: got c1=%0b at_done=%0b, expected 1 0", b1, bd);
    end
    n_checks++;
    if (n_hs !== 8 || sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL full_beats: got %0d beats (%0d pending), expected 8 (0)", n_hs, sb.size());
    end
    @(negedge wclk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_done_pulse: got %0b, expected 0", done);
    end
  endtask

  task automatic test_offset_window();
    int dc, fr, fv, r20;
    bit b1, bd;
    run_window(10, 5, 3, 1, 0, -1, dc, fr, fv, r20, b1, bd);
    n_checks++;
    if (dc !== 2 + RD_LAT + 3) begin
      n_fail++;
      $display("[TB] FAIL offset_done_cycle: got %0d, expected %0d", dc, 2 + RD_LAT + 3);
    end
    n_checks++;
    if (n_hs !== 3 || n_re !== 3 || sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL offset_counts: got beats=%0d re=%0d pending=%0d, expected 3 3 0", n_hs, n_re, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int dc, fr, fv, r20;
    bit b1, bd;
    run_window(0, 0, 4, 2, 1, -1, dc, fr, fv, r20, b1, bd);
    n_checks++;
    if (r20 !== FIFO_DEPTH) begin
      n_fail++;
      $display("[TB] FAIL bp_reads_stalled: got %0d, expected %0d", r20, FIFO_DEPTH);
    end
    n_checks++;
    if (max_out !== FIFO_DEPTH) begin
      n_fail++;
      $display("[TB] FAIL bp_outstanding: got %0d, expected %0d", max_out, FIFO_DEPTH);
    end
    n_checks++;
    if (dc < 0 || n_hs !== 8 || sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL bp_beats: got done=%0d beats=%0d pending=%0d, expected done, 8, 0", dc, n_hs, sb.size());
    end
  endtask

  task automatic test_zero_and_busy_start();
    int dc, fr, fv, r20;
    bit b1, bd;
    run_window(3, 3, 0, 2, 0, -1, dc, fr, fv, r20, b1, bd);
    n_checks++;
    if (dc !== 1 || n_re !== 0 || b1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_size: got done=%0d re=%0d busy=%0b, expected 1 0 0", dc, n_re, b1);
    end
    run_window(0, 0, 4, 2, 0, 3, dc, fr, fv, r20, b1, bd);
    repeat (10) @(posedge wclk);
    #1;
    n_checks++;
    if (dc !== 12 || n_hs !== 8 || n_re !== 8 || sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL start_while_busy: got done=%0d beats=%0d re=%0d, expected 12 8 8", dc, n_hs, n_re);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dc, fr, fv, r20;
    bit b1, bd;
    bit hit;
    hit = 1'b0;
    n_hs = 0;
    push_window(0, 0, 4, 2);
    win_x = '0; win_y = '0; win_w = COORD_W'(4); win_h = COORD_W'(2);
    bus.pix_ready = 1'b1;
    start = 1'b1;
    @(posedge wclk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge wclk); #1;
      if (n_hs == 3) hit = 1'b1;
      else begin
        @(posedge wclk); #1;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_wait: got %0d beats, expected 3", n_hs);
    end
    rst = 1'b1;
    @(negedge wclk); #1;
    n_checks++;
    if ({bus.sram_sel, bus.sram_re, bus.pix_valid, bus.pix_sof, bus.pix_eol, busy, done} !== 7'b0 ||
        bus.sram_addr !== '0 || bus.pix_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_outputs: got ctrl=%b addr=%0d data=%0d, expected all 0",
               {bus.sram_sel, bus.sram_re, bus.pix_valid, bus.pix_sof, bus.pix_eol, busy, done},
               bus.sram_addr, bus.pix_data);
    end
    @(posedge wclk); #1;
    rst = 1'b0;
    sb.delete();
    repeat (4) @(posedge wclk);
    #1;
    run_window(0, 0, 4, 2, 0, -1, dc, fr, fv, r20, b1, bd);
    n_checks++;
    if (dc !== 12 || n_hs !== 8 || sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_restart: got done=%0d beats=%0d pending=%0d, expected 12 8 0", dc, n_hs, sb.size());
    end
  endtask

  task automatic test_random_ready();
    int dc, fr, fv, r20;
    bit b1, bd;
    run_window(7, 3, 5, 3, 2, -1, dc, fr, fv, r20, b1, bd);
    n_checks++;
    if (dc < 0 || n_hs !== 15 || sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL rand_beats: got done=%0d beats=%0d pending=%0d, expected done, 15, 0", dc, n_hs, sb.size());
    end
    n_checks++;
    if (max_out > FIFO_DEPTH) begin
      n_fail++;
      $display("[TB] FAIL rand_outstanding: got %0d, expected at most %0d", max_out, FIFO_DEPTH);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_full_throughput();
    test_offset_window();
    test_backpressure();
    test_zero_and_busy_start();
    test_reset_mid_frame();
    test_random_ready();
    repeat (3) @(posedge wclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
